// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad matrix scanner.
//
// Contents:
//   DRIVE_ON / DRIVE_OFF  level driven onto a column line (active-low)
//   CNT_W                 width of the per-key debounce counter (DEBOUNCE_SCANS <= 15)
//   HEX_LEGEND            legend of a standard 4x4 pad, indexed by row*4 + col
//   key_width()           width of a key code for a given matrix size
package keypad_pkg;

    localparam logic DRIVE_ON  = 1'b0;
    localparam logic DRIVE_OFF = 1'b1;

    localparam int unsigned CNT_W = 4;

    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [3:0] HEX_LEGEND [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic int unsigned key_width(input int unsigned rows, input int unsigned cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Pin-side and consumer-side signals of the keypad matrix scanner.
//
// Signals:
//   row          raw row pins, low = key pressed in the driven column
//   col          column drive, active-low one-hot
//   key_valid    event present at FIFO head
//   key_code     code of the head event
//   key_ready    consumer accepts the head event
//   any_pressed  OR of all debounced key states
//   overflow     sticky press-dropped flag
//   ovf_clr      synchronous clear of overflow
// Modports: master = scanner side, slave = pad/consumer side.
interface keypad_matrix_scanner_if
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned NUM_COLS = 4
) ();

    localparam int unsigned KEY_W = key_width(NUM_ROWS, NUM_COLS);

    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic                key_valid;
    logic [KEY_W-1:0]    key_code;
    logic                key_ready;
    logic                any_pressed;
    logic                overflow;
    logic                ovf_clr;

    modport master (
        input  row, key_ready, ovf_clr,
        output col, key_valid, key_code, any_pressed, overflow
    );

    modport slave (
        output row, key_ready, ovf_clr,
        input  col, key_valid, key_code, any_pressed, overflow
    );

endinterface

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through event FIFO for key codes.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        push wr_data; accepted when not full, or when full and a read
//                happens in the same cycle
//   wr_data      data to push
//   full         FIFO holds DEPTH entries
//   rd_valid     head entry present
//   rd_ready     consumer pops the head when rd_valid & rd_ready
//   rd_data      head entry, 0 while empty
module keypad_event_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, rd_fire, wr_fire;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = !empty;
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_fire  = wr_en && (!full || rd_fire);
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Active-low row/column keypad scanner with per-key debounce and a press-event FIFO.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   kp     keypad_matrix_scanner_if.master: row/col pins, key_valid/key_code/key_ready
//          event stream, any_pressed, overflow, ovf_clr
//
// Optional feature: define KEYPAD_HEX_MAP_EN to report the hex legend of a 4x4 pad
// instead of the raw row*NUM_COLS + col index (4x4 matrix required).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLS       = 4,
    parameter int unsigned SCAN_TICKS     = 100000,
    parameter int unsigned SETTLE_TICKS   = 8,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    keypad_matrix_scanner_if.master kp
);

    localparam int unsigned KEY_W = key_width(NUM_ROWS, NUM_COLS);
    localparam int unsigned T_W   = $clog2(SCAN_TICKS);
    localparam int unsigned C_W   = $clog2(NUM_COLS);
    localparam int unsigned R_W   = $clog2(NUM_ROWS);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

`ifdef KEYPAD_HEX_MAP_EN
    if (NUM_ROWS != 4 || NUM_COLS != 4) begin : g_bad_size
        $error("KEYPAD_HEX_MAP_EN requires a 4x4 matrix");
    end
`endif

    // Row synchroniser; idles released (high).
    logic [NUM_ROWS-1:0] row_meta, row_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    // run holds the counters for the first edge after reset so that col stays
    // all-ones while in reset and column 0 starts with a full window.
    logic           run;
    logic [T_W-1:0] tick;
    logic [C_W-1:0] col_idx;
    logic           sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            tick    <= '0;
            col_idx <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else if (tick == T_W'(SCAN_TICKS - 1)) begin
            tick    <= '0;
            col_idx <= (col_idx == C_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign sample = run && (tick == T_W'(SETTLE_TICKS));

    always_comb begin
        kp.col = {NUM_COLS{DRIVE_OFF}};
        if (run) kp.col[col_idx] = DRIVE_ON;
    end

    // Debounce state per key.
    logic [NUM_COLS-1:0] db_q [NUM_ROWS];
    logic [NUM_COLS-1:0] db_d [NUM_ROWS];
    logic [CNT_W-1:0]    cnt_q [NUM_ROWS][NUM_COLS];
    logic [CNT_W-1:0]    cnt_d [NUM_ROWS][NUM_COLS];
    logic                press;
    logic [R_W-1:0]      press_row;

    // A row pin is high when released, so raw == db exactly when row_sync != db.
    // Only the lowest qualifying row may flip to pressed in one sample; later rows
    // park one count short and flip on a subsequent frame.
    always_comb begin
        db_d      = db_q;
        cnt_d     = cnt_q;
        press     = 1'b0;
        press_row = '0;
        if (sample) begin
            for (int r = 0; r < int'(NUM_ROWS); r++) begin
                if (row_sync[r] != db_q[r][col_idx]) begin
                    cnt_d[r][col_idx] = '0;
                end else if (cnt_q[r][col_idx] != DB_LAST) begin
                    cnt_d[r][col_idx] = cnt_q[r][col_idx] + 1'b1;
                end else if (db_q[r][col_idx]) begin
                    db_d[r][col_idx]  = 1'b0;
                    cnt_d[r][col_idx] = '0;
                end else if (!press) begin
                    db_d[r][col_idx]  = 1'b1;
                    cnt_d[r][col_idx] = '0;
                    press             = 1'b1;
                    press_row         = R_W'(r);
                end else begin
                    cnt_d[r][col_idx] = DB_LAST;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= '{default: '0};
            cnt_q <= '{default: '0};
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        kp.any_pressed = 1'b0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            kp.any_pressed = kp.any_pressed | (|db_q[r]);
        end
    end

    // Event code and FIFO.
    logic [KEY_W-1:0] raw_idx, press_code;
    logic             fifo_full, drop, ovf_q;

    assign raw_idx = KEY_W'(int'(press_row) * int'(NUM_COLS) + int'(col_idx));

`ifdef KEYPAD_HEX_MAP_EN
    assign press_code = HEX_LEGEND[raw_idx];
`else
    assign press_code = raw_idx;
`endif

    keypad_event_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (press),
        .wr_data  (press_code),
        .full     (fifo_full),
        .rd_valid (kp.key_valid),
        .rd_ready (kp.key_ready),
        .rd_data  (kp.key_code)
    );

    // A same-cycle read frees the slot, so only a write into a full FIFO with no
    // read is lost. The db flip above still happens, so no repeat event follows.
    assign drop = press && fifo_full && !(kp.key_valid && kp.key_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (kp.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign kp.overflow = ovf_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: a pin-level keypad model drives
// the rows, and a frame-level reference model predicts every output each cycle.
module tb_keypad_matrix_scanner;

    localparam int NR     = 4;
    localparam int NC     = 4;
    localparam int SCAN   = 20;
    localparam int SETTLE = 4;
    localparam int DB     = 4;
    localparam int DEPTH  = 4;
    localparam int FRAME  = SCAN * NC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    keypad_matrix_scanner_if #(.NUM_ROWS(NR), .NUM_COLS(NC)) kp_if ();

    keypad_matrix_scanner #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .SCAN_TICKS     (SCAN),
        .SETTLE_TICKS   (SETTLE),
        .DEBOUNCE_SCANS (DB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if)
    );

    always #5 clk = ~clk;

    // Physical pad: a row reads low when a pressed key sits on a driven column.
    bit   [NC-1:0] pressed [NR];
    logic [NR-1:0] row_pins;

    always_comb begin
        row_pins = '1;
        for (int r = 0; r < NR; r++) row_pins[r] = ~|(pressed[r] & ~kp_if.col);
    end
    assign kp_if.row = row_pins;

    // Reference model state.
    int m_db  [NR][NC];
    int m_cnt [NR][NC];
    int m_q   [$];
    int m_ovf;
    int n;
    int acc   [$];
    int ready_mode;
    bit rand_clr;
    bit clr_req;
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
    endtask

    function automatic int key_map(input int idx);
        int legend [16];
        legend = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
`ifdef KEYPAD_HEX_MAP_EN
        return legend[idx];
`else
        return (legend[0] * 0) + idx;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                m_db[r][c]  = 0;
                m_cnt[r][c] = 0;
            end
        m_q.delete();
        m_ovf = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        int t, cc, exp_any, code, pop, taken, clr;
        t  = n % SCAN;
        cc = (n / SCAN) % NC;
        if (t == 0) check("col", int'(kp_if.col), 15 ^ (1 << cc));
        check("key_valid", int'(kp_if.key_valid), (m_q.size() > 0) ? 1 : 0);
        check("key_code", int'(kp_if.key_code), (m_q.size() > 0) ? m_q[0] : 0);
        exp_any = 0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (m_db[r][c] != 0) exp_any = 1;
        check("any_pressed", int'(kp_if.any_pressed), exp_any);
        check("overflow", int'(kp_if.overflow), m_ovf);

        case (ready_mode)
            0:       kp_if.key_ready = 1'b0;
            1:       kp_if.key_ready = 1'b1;
            default: kp_if.key_ready = 1'($urandom_range(0, 1));
        endcase
        clr = (clr_req || (rand_clr && $urandom_range(0, 15) == 0)) ? 1 : 0;
        kp_if.ovf_clr = 1'(clr);
        clr_req = 1'b0;
        if (kp_if.key_valid && kp_if.key_ready) acc.push_back(int'(kp_if.key_code));

        pop   = (m_q.size() > 0 && kp_if.key_ready) ? 1 : 0;
        taken = 0;
        code  = -1;
        if (t == SETTLE) begin
            for (int r = 0; r < NR; r++) begin
                if (int'(pressed[r][cc]) == m_db[r][cc]) begin
                    m_cnt[r][cc] = 0;
                end else if (m_cnt[r][cc] + 1 < DB) begin
                    m_cnt[r][cc]++;
                end else if (m_db[r][cc] == 1) begin
                    m_db[r][cc]  = 0;
                    m_cnt[r][cc] = 0;
                end else if (taken == 0) begin
                    m_db[r][cc]  = 1;
                    m_cnt[r][cc] = 0;
                    taken        = 1;
                    code         = key_map(r * NC + cc);
                end else begin
                    m_cnt[r][cc] = DB - 1;
                end
            end
        end
        if (pop != 0) void'(m_q.pop_front());
        if (code >= 0 && m_q.size() >= DEPTH) m_ovf = 1;
        else begin
            if (code >= 0) m_q.push_back(code);
            if (clr != 0) m_ovf = 0;
        end

        @(negedge clk);
        n++;
    endtask

    task automatic run_frames(input int k);
        repeat (k * FRAME) step();
    endtask

    task automatic release_all();
        for (int r = 0; r < NR; r++) pressed[r] = '0;
    endtask

    initial begin
        int frames, dur;
        n_checks      = 0;
        n_pass        = 0;
        ready_mode    = 1;
        rand_clr      = 1'b0;
        clr_req       = 1'b0;
        kp_if.key_ready = 1'b0;
        kp_if.ovf_clr   = 1'b0;
        release_all();
        n = 0;

        // Values while held in reset.
        #12;
        check("rst_col", int'(kp_if.col), 15);
        check("rst_valid", int'(kp_if.key_valid), 0);
        check("rst_code", int'(kp_if.key_code), 0);
        check("rst_any", int'(kp_if.any_pressed), 0);
        check("rst_ovf", int'(kp_if.overflow), 0);
        do_reset();

        // Idle scanning.
        run_frames(2);

        // Single held key.
        acc.delete();
        pressed[1][2] = 1'b1;
        run_frames(6);
        release_all();
        run_frames(6);
        check("hold_events", acc.size(), 1);
        check("hold_code", (acc.size() > 0) ? acc[0] : -1, key_map(6));

        // Glitch shorter than the debounce window.
        acc.delete();
        pressed[0][0] = 1'b1;
        run_frames(3);
        release_all();
        run_frames(5);
        check("glitch_events", acc.size(), 0);

        // Two rows of one column pressed together.
        acc.delete();
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        run_frames(7);
        release_all();
        run_frames(6);
        check("dual_events", acc.size(), 2);
        check("dual_first", (acc.size() > 0) ? acc[0] : -1, key_map(1));
        check("dual_second", (acc.size() > 1) ? acc[1] : -1, key_map(9));

        // Five presses with the consumer stalled.
        acc.delete();
        ready_mode = 0;
        pressed[0] = 4'b1111;
        pressed[1][0] = 1'b1;
        run_frames(7);
        release_all();
        run_frames(6);
        ready_mode = 1;
        run_frames(1);
        check("ovf_drained", acc.size(), 4);
        for (int i = 0; i < 4; i++)
            check("ovf_order", (acc.size() > i) ? acc[i] : -1, key_map(i));
        check("ovf_set", int'(kp_if.overflow), 1);
        clr_req = 1'b1;
        step();
        step();
        check("ovf_cleared", int'(kp_if.overflow), 0);
        while (n % FRAME != 0) step();

        // Reset while an event is pending and a key is held.
        acc.delete();
        ready_mode = 0;
        pressed[3][3] = 1'b1;
        run_frames(6);
        check("pre_rst_valid", int'(kp_if.key_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", int'(kp_if.col), 15);
        check("mid_rst_valid", int'(kp_if.key_valid), 0);
        check("mid_rst_code", int'(kp_if.key_code), 0);
        check("mid_rst_any", int'(kp_if.any_pressed), 0);
        check("mid_rst_ovf", int'(kp_if.overflow), 0);
        do_reset();
        ready_mode = 1;
        run_frames(6);
        check("post_rst_events", acc.size(), 1);
        check("post_rst_code", (acc.size() > 0) ? acc[0] : -1, key_map(15));
        release_all();
        run_frames(6);

        // Random press patterns, random back-pressure and clears.
        ready_mode = 2;
        rand_clr   = 1'b1;
        frames     = 0;
        while (frames < 30) begin
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++)
                    pressed[r][c] = ($urandom_range(0, 4) == 0);
            dur = int'($urandom_range(1, 6));
            run_frames(dur);
            frames += dur;
        end
        release_all();
        rand_clr = 1'b0;
        run_frames(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
